stack_pointer_ctrl: RTL

- Parametrised stack-pointer unit for the 16-bit pipelined RISC core; it supersedes the fixed 8-bit SP register.
- Stack is full-descending: push pre-decrements, pop post-increments.
- Adds bounds checking with sticky overflow/underflow faults, multi-word frame allocate/release, an interrupt shadow SP with save/restore, a depth count, and the stack-memory address for the current cycle's access.
- Sits in the execute stage beside the register file; drives the data-memory address mux for PUSH/POP/CALL/RET.

---
 rtl/sp_ctrl_pkg.sv | 27 ++
 rtl/stack_pointer_ctrl_if.sv | 32 +++
 rtl/sp_addsub.sv | 12 +
 rtl/stack_pointer_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/sp_ctrl_pkg.sv
// sp_ctrl_pkg: default stack bounds and the operation priority encoding
package sp_ctrl_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam logic [7:0] SP_TOP_DEF = 8'hF0;
    localparam logic [7:0] SP_LIMIT_DEF = 8'hC0;
    localparam logic [7:0] ISR_SP_DEF = 8'hD0;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LOAD,
        OP_RESTORE,
        OP_SAVE,
        OP_ALLOC,
        OP_FREE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } op_t;

    // Highest-priority request wins; push with pop replaces the top of stack
    function automatic op_t decode_op(input logic load, input logic restore, input logic save,
                                      input logic alloc, input logic free, input logic push,
                                      input logic pop);
        return load ? OP_LOAD : restore ? OP_RESTORE : save ? OP_SAVE : alloc ? OP_ALLOC :
               free ? OP_FREE : (push && pop) ? OP_REPL : push ? OP_PUSH : pop ? OP_POP : OP_NONE;
    endfunction
endpackage

// File: rtl/stack_pointer_ctrl_if.sv
// stack_pointer_ctrl_if: request/response bundle between the execute stage and the SP unit
interface stack_pointer_ctrl_if #(parameter int ADDR_W = sp_ctrl_pkg::ADDR_W_DEF);
    logic              sp_load_en;
    logic [ADDR_W-1:0] sp_load;
    logic              push;
    logic              pop;
    logic              alloc_en;
    logic              free_en;
    logic [ADDR_W-1:0] frame_size;
    logic              ctx_save;
    logic              ctx_restore;
    logic              err_clr;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [ADDR_W:0]   depth;
    logic              ovf_err;
    logic              unf_err;
    logic              op_fault;

    modport master(
        output sp_load_en, sp_load, push, pop, alloc_en, free_en, frame_size,
               ctx_save, ctx_restore, err_clr,
        input  sp, mem_addr, mem_en, depth, ovf_err, unf_err, op_fault
    );

    modport slave(
        input  sp_load_en, sp_load, push, pop, alloc_en, free_en, frame_size,
               ctx_save, ctx_restore, err_clr,
        output sp, mem_addr, mem_en, depth, ovf_err, unf_err, op_fault
    );
endinterface

// File: rtl/sp_addsub.sv
// sp_addsub: W-bit add/subtract with carry (add) or borrow (subtract) out
module sp_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         co
);
    assign {co, y} = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/stack_pointer_ctrl.sv
// stack_pointer_ctrl: bounds-checked full-descending stack pointer with frames and ISR shadow
module stack_pointer_ctrl
    import sp_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_TOP   = ADDR_W'(SP_TOP_DEF),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEF),
    parameter logic [ADDR_W-1:0] ISR_SP   = ADDR_W'(ISR_SP_DEF)
) (
    input logic                 clk,
    input logic                 reset,
    stack_pointer_ctrl_if.slave bus
);
    localparam int W = ADDR_W + 1;

    logic [ADDR_W-1:0] sp, shadow, sp_nxt;
    logic [W-1:0]      depth, operand, res;
    logic              co, sub, legal, stack_op, bounded_op, ovf_set, unf_set;
    op_t               op;

    assign op = decode_op(bus.sp_load_en, bus.ctx_restore, bus.ctx_save, bus.alloc_en,
                          bus.free_en, bus.push, bus.pop);

    assign stack_op   = op inside {OP_PUSH, OP_POP, OP_REPL};
    assign bounded_op = stack_op || op inside {OP_ALLOC, OP_FREE};
    assign sub        = op inside {OP_PUSH, OP_ALLOC};
    assign operand    = op inside {OP_ALLOC, OP_FREE} ? {1'b0, bus.frame_size} : W'(1);

    // One adder serves both the single-word and the frame-sized moves
    sp_addsub #(.W(W)) u_addsub (
        .a  ({1'b0, sp}),
        .b  (operand),
        .sub(sub),
        .y  (res),
        .co (co)
    );

    // A borrow means the result went below zero, which can never be a legal SP
    assign legal = sub ? (!co && res >= {1'b0, SP_LIMIT}) : (res <= {1'b0, SP_TOP});

    assign ovf_set = (op == OP_LOAD && bus.sp_load < SP_LIMIT) || (bounded_op && sub && !legal);
    assign unf_set = (op == OP_LOAD && bus.sp_load > SP_TOP) || (bounded_op && !sub && !legal);

    // Next SP by operation; replace-top-of-stack keeps SP where it is
    always_comb begin
        sp_nxt = op == OP_LOAD    ? bus.sp_load :
                 op == OP_RESTORE ? shadow :
                 op == OP_SAVE    ? ISR_SP :
                 (bounded_op && legal && op != OP_REPL) ? res[ADDR_W-1:0] : sp;
    end

    // Pointer, shadow, depth and sticky faults; a new fault dominates err_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp          <= SP_TOP;
            shadow      <= SP_TOP;
            depth       <= '0;
            bus.ovf_err <= 1'b0;
            bus.unf_err <= 1'b0;
        end else begin
            sp          <= sp_nxt;
            shadow      <= op == OP_SAVE ? sp : shadow;
            depth       <= {1'b0, SP_TOP} - {1'b0, sp_nxt};
            bus.ovf_err <= ovf_set || (bus.ovf_err && !bus.err_clr);
            bus.unf_err <= unf_set || (bus.unf_err && !bus.err_clr);
        end
    end

    assign bus.sp       = sp;
    assign bus.depth    = depth;
    assign bus.mem_addr = (op == OP_PUSH && legal) ? res[ADDR_W-1:0] : sp;
    assign bus.mem_en   = stack_op && legal;
    assign bus.op_fault = bounded_op && !legal;
endmodule
